// File: rtl/parse_machine_if.sv
// Byte-stream and machine-description interfaces shared by parse_machine and its consumer.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface day10_input_if #(
    parameter int MAX_NUM_LIGHTS    = 16,
    parameter int MAX_NUM_BUTTONS   = 16,
    parameter int MAX_NUM_LIGHTS_W  = (MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
);
    logic [MAX_NUM_LIGHTS_W-1:0]  num_lights;
    logic [MAX_NUM_LIGHTS-1:0]    target_lights_arrangement;
    logic [MAX_NUM_BUTTONS_W-1:0] num_buttons;
    logic [MAX_NUM_LIGHTS-1:0]    buttons [MAX_NUM_BUTTONS];

    modport producer (output num_lights, output target_lights_arrangement,
                      output num_buttons, output buttons);
    modport consumer (input num_lights, input target_lights_arrangement,
                      input num_buttons, input buttons);
endinterface

// File: rtl/parse_machine.sv
// Byte-serial parser turning one "[.#..] (i,j) {..}" line into a machine description.
// Optional malformed-line detection and SKIP recovery: define PARSE_MACHINE_ERROR_CHECK_EN.
module parse_machine #(
    parameter int MAX_NUM_LIGHTS    = 16,
    parameter int MAX_NUM_BUTTONS   = 16,
    parameter int MAX_NUM_LIGHTS_W  = (MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int AXI_DATA_WIDTH    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_stream_if.slave     data_in,
    day10_input_if.producer day10_input,
    output logic            machine_valid,
    input  logic            machine_accepted
`ifdef PARSE_MACHINE_ERROR_CHECK_EN
    ,
    output logic            parse_error
`endif
);
    localparam int IDX_W = MAX_NUM_LIGHTS_W + 1;

    localparam logic [7:0] CH_LBRK  = 8'h5B;
    localparam logic [7:0] CH_RBRK  = 8'h5D;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LBRC  = 8'h7B;
    localparam logic [7:0] CH_RBRC  = 8'h7D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;

`ifdef PARSE_MACHINE_ERROR_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_LIGHTS, S_SEP, S_BUTTON, S_JOLT, S_EOL, S_VALID, S_SKIP} state_t;
    localparam bit     ERR_EN = 1'b1;
    localparam state_t S_DROP = S_SKIP;
`else
    typedef enum logic [2:0] {S_IDLE, S_LIGHTS, S_SEP, S_BUTTON, S_JOLT, S_EOL, S_VALID} state_t;
    localparam bit     ERR_EN = 1'b0;
    localparam state_t S_DROP = S_IDLE;
`endif

    state_t                       state_r, step_s, state_nxt_s;
    logic [AXI_DATA_WIDTH-1:0]    tdata_s;
    logic [7:0]                   byte_s;
    logic                         fire_s, is_digit_s, bad_s, err_hit_s, idx_ok_s;
    logic                         lights_full_s, buttons_full_s;
    logic [IDX_W+3:0]             idx_prod_s;
    logic [IDX_W-1:0]             idx_nxt_s, idx_r;
    logic [MAX_NUM_BUTTONS_W-1:0] btn_sel_s, num_buttons_r;
    logic [MAX_NUM_LIGHTS_W-1:0]  num_lights_r;
    logic [MAX_NUM_LIGHTS-1:0]    light_bit_s, idx_bit_s, target_r;
    logic [MAX_NUM_LIGHTS-1:0]    buttons_r [MAX_NUM_BUTTONS];
    logic                         btn_drop_r, tready_r, valid_r;

    assign tdata_s        = data_in.tdata;
    assign byte_s         = tdata_s[7:0];
    assign fire_s         = data_in.tvalid & tready_r;
    assign is_digit_s     = (byte_s >= 8'h30) && (byte_s <= 8'h39);
    assign idx_prod_s     = {4'b0000, idx_r} * (IDX_W+4)'(4'd10) + (IDX_W+4)'(byte_s[3:0]);
    assign idx_nxt_s      = (|idx_prod_s[IDX_W+3:IDX_W]) ? {IDX_W{1'b1}} : idx_prod_s[IDX_W-1:0];
    // An index is only meaningful for a light that was actually declared on this line.
    assign idx_ok_s       = idx_r < {1'b0, num_lights_r};
    assign lights_full_s  = num_lights_r >= MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS);
    assign buttons_full_s = num_buttons_r >= MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS);
    assign light_bit_s    = MAX_NUM_LIGHTS'(1'b1) << num_lights_r;
    assign idx_bit_s      = MAX_NUM_LIGHTS'(1'b1) << idx_r;
    assign btn_sel_s      = num_buttons_r - MAX_NUM_BUTTONS_W'(1'b1);
    assign err_hit_s      = bad_s || (data_in.tlast && (step_s == S_LIGHTS || step_s == S_BUTTON));

    // Byte-level transition and malformation decode, before end-of-line handling.
    always_comb begin
        step_s = state_r;
        bad_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (byte_s == CH_LBRK) step_s = S_LIGHTS;
                else bad_s = !(byte_s == CH_NL || byte_s == CH_SP || byte_s == CH_CR);
            end
            S_LIGHTS: begin
                if (byte_s == CH_DOT || byte_s == CH_HASH) bad_s = lights_full_s;
                else if (byte_s == CH_RBRK) step_s = S_SEP;
                else bad_s = 1'b1;
            end
            S_SEP: begin
                if (byte_s == CH_LPAR) begin
                    step_s = S_BUTTON;
                    bad_s  = buttons_full_s;
                end else if (byte_s == CH_LBRC) step_s = S_JOLT;
                else if (byte_s == CH_NL) step_s = S_VALID;
                else bad_s = (byte_s != CH_SP);
            end
            S_BUTTON: begin
                if (is_digit_s) bad_s = 1'b0;
                else if (byte_s == CH_COMMA) bad_s = !idx_ok_s;
                else if (byte_s == CH_RPAR) begin
                    step_s = S_SEP;
                    bad_s  = !idx_ok_s;
                end else bad_s = 1'b1;
            end
            S_JOLT: begin
                if (byte_s == CH_RBRC) step_s = S_EOL;
                else step_s = S_JOLT;
            end
            S_EOL: begin
                if (byte_s == CH_NL) step_s = S_VALID;
                else step_s = S_EOL;
            end
            default: begin
                step_s = state_r;
                bad_s  = 1'b0;
            end
        endcase
    end

    // Final next state: hand-off release, skip recovery, and tlast acting as end-of-line.
    always_comb begin
        if (state_r == S_VALID) state_nxt_s = machine_accepted ? S_IDLE : S_VALID;
        else if (!fire_s) state_nxt_s = state_r;
        else if (ERR_EN && state_r == S_DROP)
            state_nxt_s = (byte_s == CH_NL || data_in.tlast) ? S_IDLE : S_DROP;
        else if (ERR_EN && err_hit_s) state_nxt_s = data_in.tlast ? S_IDLE : S_DROP;
        else if (data_in.tlast && step_s != S_IDLE) state_nxt_s = S_VALID;
        else state_nxt_s = step_s;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            valid_r  <= 1'b0;
            tready_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            valid_r  <= (state_nxt_s == S_VALID);
            tready_r <= (state_nxt_s != S_VALID);
        end
    end

    // Field capture: each accepted byte lands in its field in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lights_r  <= '0;
            target_r      <= '0;
            num_buttons_r <= '0;
            idx_r         <= '0;
            btn_drop_r    <= 1'b0;
            for (int i = 0; i < MAX_NUM_BUTTONS; i++) buttons_r[i] <= '0;
        end else if (fire_s) begin
            case (state_r)
                S_IDLE: begin
                    if (byte_s == CH_LBRK) begin
                        num_lights_r  <= '0;
                        target_r      <= '0;
                        num_buttons_r <= '0;
                        idx_r         <= '0;
                        btn_drop_r    <= 1'b0;
                        for (int i = 0; i < MAX_NUM_BUTTONS; i++) buttons_r[i] <= '0;
                    end
                end
                S_LIGHTS: begin
                    if ((byte_s == CH_DOT || byte_s == CH_HASH) && !lights_full_s) begin
                        num_lights_r <= num_lights_r + MAX_NUM_LIGHTS_W'(1'b1);
                        if (byte_s == CH_HASH) target_r <= target_r | light_bit_s;
                    end
                end
                S_SEP: begin
                    if (byte_s == CH_LPAR) begin
                        idx_r <= '0;
                        if (buttons_full_s) btn_drop_r <= 1'b1;
                        else begin
                            num_buttons_r <= num_buttons_r + MAX_NUM_BUTTONS_W'(1'b1);
                            btn_drop_r    <= 1'b0;
                        end
                    end
                end
                S_BUTTON: begin
                    if (is_digit_s) idx_r <= idx_nxt_s;
                    else if (byte_s == CH_COMMA || byte_s == CH_RPAR) begin
                        idx_r <= '0;
                        if (!btn_drop_r && idx_ok_s) begin
                            for (int i = 0; i < MAX_NUM_BUTTONS; i++)
                                if (btn_sel_s == MAX_NUM_BUTTONS_W'(i))
                                    buttons_r[i] <= buttons_r[i] | idx_bit_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PARSE_MACHINE_ERROR_CHECK_EN
    logic parse_error_r;

    // Sticky malformed-line flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parse_error_r <= 1'b0;
        else if (fire_s && state_r != S_SKIP && err_hit_s) parse_error_r <= 1'b1;
        else parse_error_r <= parse_error_r;
    end

    assign parse_error = parse_error_r;
`endif

    assign data_in.tready                        = tready_r;
    assign machine_valid                         = valid_r;
    assign day10_input.num_lights                = num_lights_r;
    assign day10_input.target_lights_arrangement = target_r;
    assign day10_input.num_buttons               = num_buttons_r;

    for (genvar g = 0; g < MAX_NUM_BUTTONS; g++) begin : g_btn
        assign day10_input.buttons[g] = buttons_r[g];
    end
endmodule

// File: tb/tb_parse_machine.sv
// Self-checking bench for parse_machine: directed lines plus randomized machines.
`timescale 1ns/1ps
module tb_parse_machine;
    localparam int NL  = 12;
    localparam int NB  = 8;
    localparam int NLW = 4;
    localparam int NBW = 4;
    localparam string EXAMPLE = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}";

    logic clk = 1'b0;
    logic rst_n;
    logic machine_valid;
    logic machine_accepted;
`ifdef PARSE_MACHINE_ERROR_CHECK_EN
    logic parse_error;
`endif
    int checks = 0;
    int errors = 0;

    axi_stream_if #(.DATA_WIDTH(8)) axi ();
    day10_input_if #(.MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB)) d10 ();

    parse_machine #(.MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in          (axi),
        .day10_input      (d10),
        .machine_valid    (machine_valid),
        .machine_accepted (machine_accepted)
`ifdef PARSE_MACHINE_ERROR_CHECK_EN
        ,
        .parse_error      (parse_error)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    function automatic logic [NB*NL-1:0] obs_buttons();
        logic [NB*NL-1:0] v;
        for (int i = 0; i < NB; i++) v[i*NL +: NL] = d10.buttons[i];
        return v;
    endfunction

    function automatic logic [NB*NL-1:0] example_buttons();
        logic [NB*NL-1:0] v;
        v = '0;
        v[0*NL +: NL] = 12'h008;
        v[1*NL +: NL] = 12'h00A;
        v[2*NL +: NL] = 12'h004;
        v[3*NL +: NL] = 12'h00C;
        v[4*NL +: NL] = 12'h005;
        v[5*NL +: NL] = 12'h003;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        axi.tdata  = b;
        axi.tvalid = 1'b1;
        axi.tlast  = last;
        waited     = 0;
        while (axi.tready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (axi.tready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout byte=%h tready=%b required 1", b, axi.tready);
        end else begin
            @(posedge clk); #1;
        end
        axi.tvalid = 1'b0;
        axi.tlast  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_on_end);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last_on_end && (i == s.len() - 1));
    endtask

    task automatic accept();
        machine_accepted = 1'b1;
        @(posedge clk); #1;
        machine_accepted = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (machine_valid !== 1'b0 || axi.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs valid=%b tready=%b required 0/0", machine_valid, axi.tready);
        end
        checks++;
        if (d10.num_lights !== 4'd0 || d10.num_buttons !== 4'd0 ||
            d10.target_lights_arrangement !== 12'h000 || obs_buttons() !== '0) begin
            errors++;
            $display("FAIL reset_fields nl=%0d nb=%0d tgt=%h required all 0",
                     d10.num_lights, d10.num_buttons, d10.target_lights_arrangement);
        end
`ifdef PARSE_MACHINE_ERROR_CHECK_EN
        checks++;
        if (parse_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_perr parse_error=%b required 0", parse_error);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (axi.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release tready=%b required 1", axi.tready);
        end
    endtask

    task automatic test_example();
        send_str(EXAMPLE, 1'b0);
        checks++;
        if (machine_valid !== 1'b0) begin
            errors++;
            $display("FAIL ex_early_valid valid=%b required 0", machine_valid);
        end
        send_byte(8'h0A, 1'b0);
        checks++;
        if (machine_valid !== 1'b1) begin
            errors++;
            $display("FAIL ex_valid valid=%b required 1", machine_valid);
        end
        checks++;
        if (d10.num_lights !== 4'd4 || d10.target_lights_arrangement !== 12'h006 ||
            d10.num_buttons !== 4'd6) begin
            errors++;
            $display("FAIL ex_fields nl=%0d tgt=%h nb=%0d required 4/006/6",
                     d10.num_lights, d10.target_lights_arrangement, d10.num_buttons);
        end
        checks++;
        if (obs_buttons() !== example_buttons()) begin
            errors++;
            $display("FAIL ex_buttons got=%h required %h", obs_buttons(), example_buttons());
        end
    endtask

    task automatic test_hold();
        axi.tdata  = 8'h5B;
        axi.tvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (axi.tready !== 1'b0 || machine_valid !== 1'b1 || d10.num_lights !== 4'd4 ||
                obs_buttons() !== example_buttons()) begin
                errors++;
                $display("FAIL hold cycle=%0d tready=%b valid=%b nl=%0d required 0/1/4",
                         c, axi.tready, machine_valid, d10.num_lights);
            end
        end
        axi.tvalid = 1'b0;
        accept();
        checks++;
        if (machine_valid !== 1'b0 || axi.tready !== 1'b1 || d10.num_lights !== 4'd4) begin
            errors++;
            $display("FAIL hold_release valid=%b tready=%b nl=%0d required 0/1/4",
                     machine_valid, axi.tready, d10.num_lights);
        end
        send_str("[#..#.] (0,4) (1) {9}\n", 1'b0);
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd5 ||
            d10.target_lights_arrangement !== 12'h009 || d10.num_buttons !== 4'd2 ||
            obs_buttons() !== {{(NB-2)*NL{1'b0}}, 12'h002, 12'h011}) begin
            errors++;
            $display("FAIL second_line valid=%b nl=%0d tgt=%h nb=%0d btn=%h required 1/5/009/2/..002011",
                     machine_valid, d10.num_lights, d10.target_lights_arrangement,
                     d10.num_buttons, obs_buttons());
        end
        accept();
    endtask

    task automatic test_tlast();
        send_str(EXAMPLE, 1'b1);
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd4 || d10.num_buttons !== 4'd6 ||
            obs_buttons() !== example_buttons()) begin
            errors++;
            $display("FAIL tlast_valid valid=%b nl=%0d nb=%0d required 1/4/6",
                     machine_valid, d10.num_lights, d10.num_buttons);
        end
        accept();
        send_str("\n\n", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (machine_valid !== 1'b0 || axi.tready !== 1'b1) begin
            errors++;
            $display("FAIL blank_line valid=%b tready=%b required 0/1", machine_valid, axi.tready);
        end
        send_str("[#] (0)\n", 1'b0);
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd1 ||
            d10.target_lights_arrangement !== 12'h001 || obs_buttons() !== {{(NB-1)*NL{1'b0}}, 12'h001}) begin
            errors++;
            $display("FAIL after_blank valid=%b nl=%0d tgt=%h required 1/1/001",
                     machine_valid, d10.num_lights, d10.target_lights_arrangement);
        end
        accept();
    endtask

    task automatic test_multidigit();
        send_str("[............] (11,10)\n", 1'b0);
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd12 || d10.num_buttons !== 4'd1 ||
            d10.target_lights_arrangement !== 12'h000 || obs_buttons() !== {{(NB-1)*NL{1'b0}}, 12'hC00}) begin
            errors++;
            $display("FAIL multidigit valid=%b nl=%0d nb=%0d btn=%h required 1/12/1/..C00",
                     machine_valid, d10.num_lights, d10.num_buttons, obs_buttons());
        end
        accept();
    endtask

    task automatic test_bad_index();
        send_str("[.#] (5)\n", 1'b0);
`ifdef PARSE_MACHINE_ERROR_CHECK_EN
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (machine_valid !== 1'b0 || parse_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_index valid=%b perr=%b required 0/1", machine_valid, parse_error);
        end
        send_str("[##] (0) (1)\n", 1'b0);
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd2 || d10.num_buttons !== 4'd2 ||
            d10.target_lights_arrangement !== 12'h003 ||
            obs_buttons() !== {{(NB-2)*NL{1'b0}}, 12'h002, 12'h001}) begin
            errors++;
            $display("FAIL after_error valid=%b nl=%0d nb=%0d btn=%h required 1/2/2/..002001",
                     machine_valid, d10.num_lights, d10.num_buttons, obs_buttons());
        end
`else
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd2 || d10.num_buttons !== 4'd1 ||
            d10.target_lights_arrangement !== 12'h002 || obs_buttons() !== '0) begin
            errors++;
            $display("FAIL bad_index_lenient valid=%b nl=%0d nb=%0d tgt=%h btn=%h required 1/2/1/002/0",
                     machine_valid, d10.num_lights, d10.num_buttons,
                     d10.target_lights_arrangement, obs_buttons());
        end
`endif
        accept();
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            string s;
            int n, m;
            bit use_tlast;
            logic [NL-1:0] tgt, mask;
            logic [NB*NL-1:0] btns;
            bit first;
            n = $urandom_range(1, NL);
            m = $urandom_range(1, NB);
            use_tlast = $urandom_range(0, 1);
            tgt = '0;
            btns = '0;
            s = ($urandom_range(0, 3) == 0) ? "\n[" : "[";
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    tgt[i] = 1'b1;
                    s = {s, "#"};
                end else s = {s, "."};
            end
            s = {s, "]"};
            for (int j = 0; j < m; j++) begin
                do mask = NL'($urandom) & ((NL'(1) << n) - NL'(1)); while (mask == '0);
                btns[j*NL +: NL] = mask;
                s = {s, " ("};
                first = 1'b1;
                for (int k = 0; k < n; k++) begin
                    if (mask[k]) begin
                        if (!first) s = {s, ","};
                        s = {s, $sformatf("%0d", k)};
                        first = 1'b0;
                    end
                end
                s = {s, ")"};
            end
            s = {s, $sformatf(" {%0d,%0d}", $urandom_range(0, 300), $urandom_range(0, 300))};
            if (!use_tlast) s = {s, "\n"};
            send_str(s, use_tlast);
            checks++;
            if (machine_valid !== 1'b1 || d10.num_lights !== NLW'(n) || d10.num_buttons !== NBW'(m) ||
                d10.target_lights_arrangement !== tgt || obs_buttons() !== btns) begin
                errors++;
                $display("FAIL random[%0d] valid=%b nl=%0d nb=%0d tgt=%h btn=%h required 1/%0d/%0d/%h/%h",
                         t, machine_valid, d10.num_lights, d10.num_buttons,
                         d10.target_lights_arrangement, obs_buttons(), n, m, tgt, btns);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            accept();
        end
    endtask

    task automatic test_reset_mid();
        send_str("[.##.] (1,2", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (machine_valid !== 1'b0 || axi.tready !== 1'b0 || d10.num_lights !== 4'd0 ||
            d10.num_buttons !== 4'd0 || d10.target_lights_arrangement !== 12'h000 || obs_buttons() !== '0) begin
            errors++;
            $display("FAIL async_reset valid=%b tready=%b nl=%0d nb=%0d required all 0",
                     machine_valid, axi.tready, d10.num_lights, d10.num_buttons);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`ifdef PARSE_MACHINE_ERROR_CHECK_EN
        checks++;
        if (parse_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_perr parse_error=%b required 0", parse_error);
        end
`endif
        send_str({EXAMPLE, "\n"}, 1'b0);
        checks++;
        if (machine_valid !== 1'b1 || d10.num_lights !== 4'd4 ||
            d10.target_lights_arrangement !== 12'h006 || obs_buttons() !== example_buttons()) begin
            errors++;
            $display("FAIL post_reset_line valid=%b nl=%0d tgt=%h required 1/4/006",
                     machine_valid, d10.num_lights, d10.target_lights_arrangement);
        end
        accept();
    endtask

    initial begin
        axi.tdata        = 8'h00;
        axi.tvalid       = 1'b0;
        axi.tlast        = 1'b0;
        machine_accepted = 1'b0;
        rst_n            = 1'b0;
        test_reset();
        test_example();
        test_hold();
        test_tlast();
        test_multidigit();
        test_bad_index();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
